// File: rtl/fadd_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with valid/ready flow control.
// Define FADD_PIPE_FTZ_EN to flush denormal inputs and results to signed zero.
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic                     sub,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     res,
    output logic                     ovf,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int XW = EXP_W + 1;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] SW_E = EXP_W'(SW);

    function automatic logic [XW-1:0] lzc_f(input logic [SW-1:0] v);
        lzc_f = XW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) lzc_f = XW'(SW - 1 - i);
        end
    endfunction

    // ---------------- pipeline control ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;
    logic ld1, ld2, ld3;

    // Empty stages keep loading so bubbles collapse under backpressure.
    assign ld3      = !s3_valid_q || out_ready;
    assign ld2      = ld3 || !s2_valid_q;
    assign ld1      = ld2 || !s1_valid_q;
    assign in_ready = !(s3_valid_q && !out_ready);

    // ---------------- stage 1: unpack / align ----------------
    logic              a_s, b_s;
    logic [EXP_W-1:0]  a_e, b_e, a_ee, b_ee;
    logic [MAN_W-1:0]  a_f, b_f;
    logic [SW-1:0]     a_m, b_m;
    logic              a_nan, b_nan, a_inf, b_inf;
    logic              l_s, s_s;
    logic [EXP_W-1:0]  l_e, s_e, e_diff, e_sh;
    logic [SW-1:0]     l_m, s_m, s_al;
    logic [2*SW-1:0]   ext;
    logic              sp1;
    logic [W-1:0]      sp1_res;

    assign a_s = a[W-1];
    assign a_e = a[W-2:MAN_W];
    assign a_f = a[MAN_W-1:0];
    assign b_s = b[W-1] ^ sub;
    assign b_e = b[W-2:MAN_W];
    assign b_f = b[MAN_W-1:0];

    always_comb begin
        a_nan = (a_e == EMAX) && (a_f != '0);
        b_nan = (b_e == EMAX) && (b_f != '0);
        a_inf = (a_e == EMAX) && (a_f == '0);
        b_inf = (b_e == EMAX) && (b_f == '0);
        a_ee  = (a_e == '0) ? EXP_W'(1) : a_e;
        b_ee  = (b_e == '0) ? EXP_W'(1) : b_e;
        a_m   = {a_e != '0, a_f, 3'b000};
        b_m   = {b_e != '0, b_f, 3'b000};
`ifdef FADD_PIPE_FTZ_EN
        if (a_e == '0) a_m = '0;
        if (b_e == '0) b_m = '0;
`endif
        if ({b_ee, b_m} > {a_ee, a_m}) begin
            l_s = b_s; l_e = b_ee; l_m = b_m;
            s_s = a_s; s_e = a_ee; s_m = a_m;
        end else begin
            l_s = a_s; l_e = a_ee; l_m = a_m;
            s_s = b_s; s_e = b_ee; s_m = b_m;
        end
        e_diff = l_e - s_e;
        e_sh   = (e_diff > SW_E) ? SW_E : e_diff;
        ext    = {s_m, {SW{1'b0}}} >> e_sh;
        s_al   = ext[2*SW-1:SW] | {{(SW-1){1'b0}}, |ext[SW-1:0]};

        sp1     = 1'b1;
        sp1_res = '0;
        if (b_nan)
            sp1_res = {b[W-1], EMAX, 1'b1, b_f[MAN_W-2:0]};
        else if (a_nan)
            sp1_res = {a_s, EMAX, 1'b1, a_f[MAN_W-2:0]};
        else if (a_inf && b_inf && (a_s != b_s))
            sp1_res = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        else if (a_inf)
            sp1_res = {a_s, EMAX, {MAN_W{1'b0}}};
        else if (b_inf)
            sp1_res = {b_s, EMAX, {MAN_W{1'b0}}};
        else
            sp1 = 1'b0;
    end

    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_ls_q, s1_ls_d, s1_ss_q, s1_ss_d;
    logic [EXP_W-1:0] s1_e_q, s1_e_d;
    logic [SW-1:0]    s1_lm_q, s1_lm_d, s1_sm_q, s1_sm_d;
    logic             s1_sp_q, s1_sp_d;
    logic [W-1:0]     s1_sres_q, s1_sres_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_ls_d    = s1_ls_q;
        s1_ss_d    = s1_ss_q;
        s1_e_d     = s1_e_q;
        s1_lm_d    = s1_lm_q;
        s1_sm_d    = s1_sm_q;
        s1_sp_d    = s1_sp_q;
        s1_sres_d  = s1_sres_q;
        if (ld1) begin
            s1_valid_d = in_valid && in_ready;
            s1_tag_d   = in_tag;
            s1_ls_d    = l_s;
            s1_ss_d    = s_s;
            s1_e_d     = l_e;
            s1_lm_d    = l_m;
            s1_sm_d    = s_al;
            s1_sp_d    = sp1;
            s1_sres_d  = sp1_res;
        end
    end

    // ---------------- stage 2: add ----------------
    logic             eff_sub;
    logic [SW:0]      sum2;
    logic             sgn2;

    always_comb begin
        eff_sub = s1_ls_q ^ s1_ss_q;
        if (eff_sub) sum2 = {1'b0, s1_lm_q} - {1'b0, s1_sm_q};
        else         sum2 = {1'b0, s1_lm_q} + {1'b0, s1_sm_q};
        // Exact cancellation yields +0; like-signed zeros keep their sign.
        sgn2 = (eff_sub && (sum2 == '0)) ? 1'b0 : s1_ls_q;
    end

    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_s_q, s2_s_d;
    logic [EXP_W-1:0] s2_e_q, s2_e_d;
    logic [SW:0]      s2_sum_q, s2_sum_d;
    logic             s2_sp_q, s2_sp_d;
    logic [W-1:0]     s2_sres_q, s2_sres_d;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_tag_d   = s2_tag_q;
        s2_s_d     = s2_s_q;
        s2_e_d     = s2_e_q;
        s2_sum_d   = s2_sum_q;
        s2_sp_d    = s2_sp_q;
        s2_sres_d  = s2_sres_q;
        if (ld2) begin
            s2_valid_d = s1_valid_q;
            s2_tag_d   = s1_tag_q;
            s2_s_d     = sgn2;
            s2_e_d     = s1_e_q;
            s2_sum_d   = sum2;
            s2_sp_d    = s1_sp_q;
            s2_sres_d  = s1_sres_q;
        end
    end

    // ---------------- stage 3: normalize / round ----------------
    logic [XW-1:0]    ex, lz, nsh, eo;
    logic [SW-1:0]    m3;
    logic             inc;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] fo;
    logic [W-1:0]     res3;
    logic             ovf3;

    always_comb begin
        ex  = {1'b0, s2_e_q};
        lz  = '0;
        nsh = '0;
        if (s2_sum_q[SW]) begin
            m3 = {s2_sum_q[SW:2], |s2_sum_q[1:0]};
            ex = ex + XW'(1);
        end else begin
            // Left shift stops at exponent 1; anything short of hidden=1 is denormal.
            lz  = lzc_f(s2_sum_q[SW-1:0]);
            nsh = (lz < ex - XW'(1)) ? lz : ex - XW'(1);
            m3  = s2_sum_q[SW-1:0] << nsh;
            ex  = ex - nsh;
        end
        inc = m3[2] && (m3[1] || m3[0] || m3[3]);
        rnd = {1'b0, m3[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
        if (rnd[MAN_W+1]) begin
            eo = ex + XW'(1);
            fo = rnd[MAN_W:1];
        end else begin
            eo = rnd[MAN_W] ? ex : '0;
            fo = rnd[MAN_W-1:0];
        end
        ovf3 = 1'b0;
        if (eo >= {1'b0, EMAX}) begin
            res3 = {s2_s_q, EMAX, {MAN_W{1'b0}}};
            ovf3 = 1'b1;
        end else begin
            res3 = {s2_s_q, eo[EXP_W-1:0], fo};
`ifdef FADD_PIPE_FTZ_EN
            if (eo == '0) res3 = {s2_s_q, {(W-1){1'b0}}};
`endif
        end
        if (s2_sp_q) begin
            res3 = s2_sres_q;
            ovf3 = 1'b0;
        end
    end

    logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
    logic [W-1:0]     s3_res_q, s3_res_d;
    logic             s3_ovf_q, s3_ovf_d;

    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_tag_d   = s3_tag_q;
        s3_res_d   = s3_res_q;
        s3_ovf_d   = s3_ovf_q;
        if (ld3) begin
            s3_valid_d = s2_valid_q;
            s3_tag_d   = s2_tag_q;
            s3_res_d   = res3;
            s3_ovf_d   = ovf3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_ls_q    <= 1'b0;
            s1_ss_q    <= 1'b0;
            s1_e_q     <= '0;
            s1_lm_q    <= '0;
            s1_sm_q    <= '0;
            s1_sp_q    <= 1'b0;
            s1_sres_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_s_q     <= 1'b0;
            s2_e_q     <= '0;
            s2_sum_q   <= '0;
            s2_sp_q    <= 1'b0;
            s2_sres_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_tag_q   <= '0;
            s3_res_q   <= '0;
            s3_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_ls_q    <= s1_ls_d;
            s1_ss_q    <= s1_ss_d;
            s1_e_q     <= s1_e_d;
            s1_lm_q    <= s1_lm_d;
            s1_sm_q    <= s1_sm_d;
            s1_sp_q    <= s1_sp_d;
            s1_sres_q  <= s1_sres_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_s_q     <= s2_s_d;
            s2_e_q     <= s2_e_d;
            s2_sum_q   <= s2_sum_d;
            s2_sp_q    <= s2_sp_d;
            s2_sres_q  <= s2_sres_d;
            s3_valid_q <= s3_valid_d;
            s3_tag_q   <= s3_tag_d;
            s3_res_q   <= s3_res_d;
            s3_ovf_q   <= s3_ovf_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign res       = s3_res_q;
    assign ovf       = s3_ovf_q;
    assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_fadd_pipe.sv
// Scoreboard bench for fadd_pipe: directed single-precision vectors,
// backpressure and mid-flight reset.
module tb_fadd_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        ovf;
    logic [3:0]  out_tag;

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic [3:0]  t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    fadd_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .ovf(ovf), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out res=%h ovf=%b tag=%0d", res, ovf, out_tag);
            end else begin
                mon_e = sb.pop_front();
                if (res !== mon_e.r || ovf !== mon_e.o || out_tag !== mon_e.t) begin
                    miscompares++;
                    $display("FAIL result tag%0d: got res=%h ovf=%b tag=%0d, want res=%h ovf=%b tag=%0d",
                             mon_e.t, res, ovf, out_tag, mon_e.r, mon_e.o, mon_e.t);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic ss,
                         input logic [3:0] tg, input logic [31:0] er, input logic eo);
        bit ok;
        ok = 0;
        a = aa; b = bb; sub = ss; in_tag = tg; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout tag%0d: in_ready stuck at 0", tg);
            in_valid = 1'b0;
        end else begin
            sb.push_back('{er, eo, tg});
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_ovf_tag", {27'd0, ovf, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd5, 32'h40000000, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("latency", 32'(n), 32'd3);
        drain();

        issue(32'h3F800000, 32'h3F800000, 1'b1, 4'd1, 32'h00000000, 1'b0);
        issue(32'h4B800000, 32'h3F800000, 1'b0, 4'd2, 32'h4B800000, 1'b0);
        issue(32'h4B800000, 32'h40400000, 1'b0, 4'd3, 32'h4B800002, 1'b0);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd4, 32'h7F800000, 1'b1);
        issue(32'h7F800000, 32'hFF800000, 1'b0, 4'd6, 32'h7FC00000, 1'b0);
        issue(32'h3FC00000, 32'h3F000000, 1'b1, 4'd7, 32'h3F800000, 1'b0);
        issue(32'h3F800000, 32'h7F800001, 1'b0, 4'd8, 32'h7FC00001, 1'b0);
        issue(32'h7F800000, 32'h3F800000, 1'b0, 4'd9, 32'h7F800000, 1'b0);
        issue(32'h80000000, 32'h80000000, 1'b0, 4'd10, 32'h80000000, 1'b0);
        issue(32'h3F800000, 32'hBF800000, 1'b0, 4'd11, 32'h00000000, 1'b0);
`ifdef FADD_PIPE_FTZ_EN
        issue(32'h00000001, 32'h00000001, 1'b0, 4'd12, 32'h00000000, 1'b0);
        issue(32'h00400000, 32'h00400000, 1'b0, 4'd13, 32'h00000000, 1'b0);
`else
        issue(32'h00000001, 32'h00000001, 1'b0, 4'd12, 32'h00000002, 1'b0);
        issue(32'h00400000, 32'h00400000, 1'b0, 4'd13, 32'h00800000, 1'b0);
`endif
        drain();

        out_ready = 1'b0;
        issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 32'h40000000, 1'b0);
        issue(32'h40000000, 32'h3F800000, 1'b0, 4'd2, 32'h40400000, 1'b0);
        issue(32'h40400000, 32'h3F800000, 1'b0, 4'd3, 32'h40800000, 1'b0);
        fork
            begin
                issue(32'h40800000, 32'h3F800000, 1'b0, 4'd4, 32'h40A00000, 1'b0);
                issue(32'h40A00000, 32'h3F800000, 1'b0, 4'd5, 32'h40C00000, 1'b0);
            end
        join_none
        repeat (4) @(negedge clk);
        chk("bp_in_flight", 32'(sb.size()), 32'd3);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_res", res, 32'h40000000);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait fork;
        drain();

        issue(32'h3F800000, 32'h3F800000, 1'b0, 4'd14, 32'h40000000, 1'b0);
        issue(32'h40000000, 32'h40000000, 1'b0, 4'd15, 32'h40800000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        sb.delete();
        rst = 1'b0;
        chk("rst_flush_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        chk("rst_no_stale", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
